// File: rtl/button_press_classifier.sv
// Push-button front end: 2-flop synchronizer, counter debouncer and press-duration classifier.
// Optional auto-repeat stream for held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module button_press_classifier #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 1500000,
  parameter int REPEAT_CYCLES   = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic                s1;
  logic                s2;
  logic [DB_W-1:0]     db_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                toggle;
  logic                rise;
  logic                fall;
  logic                short_d;
  logic                short_pend;
  logic                long_d;
  logic                repeat_d;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Debouncer: a level change is accepted only after it stays stable long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (s2 == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Strobes mark the cycle whose clock edge commits the new debounced level
  assign toggle = (s2 != btn_level) && (db_cnt == DB_LAST);
  assign rise   = toggle && s2;
  assign fall   = toggle && !s2;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; a release on the threshold cycle beats the long classification
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rise) next_state = PRESSED;
        else      next_state = IDLE;
      end
      PRESSED: begin
        if (fall)                       next_state = IDLE;
        else if (hold_cnt == HOLD_LAST) next_state = HELD;
        else                            next_state = PRESSED;
      end
      HELD: begin
        if (fall) next_state = IDLE;
        else      next_state = HELD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Hold-time counter, only running while the press is still unclassified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if ((state == PRESSED) && (next_state == PRESSED)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt;

  // Auto-repeat period counter, wrapping on every repeat while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if ((state == HELD) && !fall) begin
      if (rep_cnt == REP_LAST) rep_cnt <= '0;
      else                     rep_cnt <= rep_cnt + REP_W'(1);
    end else begin
      rep_cnt <= '0;
    end
  end
`endif

  // FSM output decode, feeding the registered pulse outputs
  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state)
      PRESSED: begin
        if (fall) begin
          short_d = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          long_d = 1'b1;
        end else begin
          short_d = 1'b0;
        end
      end
      HELD: begin
`ifdef BTN_AUTOREPEAT_EN
        if (!fall && (rep_cnt == REP_LAST)) repeat_d = 1'b1;
        else                                repeat_d = 1'b0;
`else
        repeat_d = 1'b0;
`endif
      end
      default: begin
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
      end
    endcase
  end

  // Registered pulses; the short report lands one cycle after the debounced level drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_pend   <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      short_pend   <= short_d;
      short_pulse  <= short_pend;
      long_pulse   <= long_d;
      repeat_pulse <= repeat_d;
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with DEBOUNCE=4, LONG=20, REPEAT=8.
// Expectations adapt to BTN_AUTOREPEAT_EN when the bench is built with it.
module tb_button_press_classifier;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;

  int checks = 0;
  int fails = 0;
  int t = 0;
  logic prev_level = 1'b0;
  int rise_n, fall_n, rise_t, fall_t;
  int short_n, short_t, long_n, long_t, rep_n, both_n;
  int rep_t[$];
  int t0, tr, exp_rep;

  button_press_classifier #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task clear_log;
    rise_n = 0; fall_n = 0; rise_t = -1; fall_t = -1;
    short_n = 0; short_t = -1; long_n = 0; long_t = -1;
    rep_n = 0; both_n = 0;
    rep_t.delete();
  endtask

  task observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t++;
      if (btn_level && !prev_level) begin rise_n++; rise_t = t; end
      if (!btn_level && prev_level) begin fall_n++; fall_t = t; end
      if (short_pulse) begin short_n++; short_t = t; end
      if (long_pulse) begin long_n++; long_t = t; end
      if (repeat_pulse) begin rep_n++; rep_t.push_back(t); end
      if (short_pulse && long_pulse) both_n++;
      prev_level = btn_level;
    end
  endtask

  task test_reset;
    btn_raw = 1'b1;
    rst_n = 1'b0;
    clear_log();
    observe(3);
    checks++;
    if ({btn_level, short_pulse, long_pulse, repeat_pulse} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0000", {btn_level, short_pulse, long_pulse, repeat_pulse});
    end
    rst_n = 1'b1;
    t0 = t;
    observe(30);
    checks++;
    if (rise_t !== t0 + 6) begin fails++; $display("FAIL reset_rise_time: got %0d expected %0d", rise_t, t0 + 6); end
    checks++;
    if (long_t !== t0 + 26) begin fails++; $display("FAIL reset_long_time: got %0d expected %0d", long_t, t0 + 26); end
    btn_raw = 1'b0;
    observe(10);
    checks++;
    if (short_n !== 0 || long_n !== 1) begin
      fails++;
      $display("FAIL reset_pulse_counts: got short=%0d long=%0d expected short=0 long=1", short_n, long_n);
    end
  endtask

  task test_bounce;
    clear_log();
    btn_raw = 1'b1; observe(2);
    btn_raw = 1'b0; observe(2);
    btn_raw = 1'b1; observe(2);
    btn_raw = 1'b0; observe(2);
    btn_raw = 1'b1; t0 = t;
    observe(6);
    checks++;
    if (rise_n !== 1 || rise_t !== t0 + 6) begin
      fails++;
      $display("FAIL bounce_rise: got count=%0d time=%0d expected count=1 time=%0d", rise_n, rise_t, t0 + 6);
    end
    checks++;
    if (short_n + long_n + rep_n !== 0) begin
      fails++;
      $display("FAIL bounce_no_pulse: got %0d pulses expected 0", short_n + long_n + rep_n);
    end
    btn_raw = 1'b0;
    observe(10);
  endtask

  task test_short_press;
    clear_log();
    btn_raw = 1'b1;
    observe(6);
    tr = rise_t;
    observe(10);
    btn_raw = 1'b0;
    observe(10);
    checks++;
    if (fall_t !== tr + 16) begin fails++; $display("FAIL short_fall_time: got %0d expected %0d", fall_t, tr + 16); end
    checks++;
    if (short_n !== 1 || short_t !== tr + 17) begin
      fails++;
      $display("FAIL short_pulse: got count=%0d time=%0d expected count=1 time=%0d", short_n, short_t, tr + 17);
    end
    checks++;
    if (long_n !== 0) begin fails++; $display("FAIL short_no_long: got %0d expected 0", long_n); end
  endtask

  task test_long_press;
    clear_log();
    btn_raw = 1'b1;
    observe(6);
    tr = rise_t;
    observe(40);
    btn_raw = 1'b0;
    observe(10);
`ifdef BTN_AUTOREPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 0;
`endif
    checks++;
    if (long_n !== 1 || long_t !== tr + 20) begin
      fails++;
      $display("FAIL long_pulse: got count=%0d time=%0d expected count=1 time=%0d", long_n, long_t, tr + 20);
    end
    checks++;
    if (short_n !== 0) begin fails++; $display("FAIL long_no_short: got %0d expected 0", short_n); end
    checks++;
    if (rep_n !== exp_rep) begin fails++; $display("FAIL long_repeat_count: got %0d expected %0d", rep_n, exp_rep); end
  endtask

  task test_auto_repeat;
    clear_log();
    btn_raw = 1'b1;
    observe(6);
    tr = rise_t;
    observe(45);
    btn_raw = 1'b0;
    observe(20);
    checks++;
    if (long_t !== tr + 20) begin fails++; $display("FAIL repeat_long_time: got %0d expected %0d", long_t, tr + 20); end
`ifdef BTN_AUTOREPEAT_EN
    checks++;
    if (rep_n !== 3) begin fails++; $display("FAIL repeat_count: got %0d expected 3", rep_n); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ((rep_t.size() > k ? rep_t[k] : -1) !== tr + 28 + 8 * k) begin
        fails++;
        $display("FAIL repeat_time_%0d: got %0d expected %0d", k, (rep_t.size() > k ? rep_t[k] : -1), tr + 28 + 8 * k);
      end
    end
`else
    checks++;
    if (rep_n !== 0) begin fails++; $display("FAIL repeat_disabled: got %0d expected 0", rep_n); end
`endif
    checks++;
    if (short_n !== 0) begin fails++; $display("FAIL repeat_no_short: got %0d expected 0", short_n); end
  endtask

  task test_threshold_race;
    // Release landing exactly on the threshold cycle is short
    clear_log();
    btn_raw = 1'b1;
    observe(6);
    tr = rise_t;
    observe(14);
    btn_raw = 1'b0;
    observe(12);
    checks++;
    if (fall_t !== tr + 20) begin fails++; $display("FAIL race_fall_time: got %0d expected %0d", fall_t, tr + 20); end
    checks++;
    if (short_n !== 1 || short_t !== tr + 21 || long_n !== 0) begin
      fails++;
      $display("FAIL race_short_wins: got short=%0d@%0d long=%0d expected short=1@%0d long=0", short_n, short_t, long_n, tr + 21);
    end
    // One cycle later the press is already long
    clear_log();
    btn_raw = 1'b1;
    observe(6);
    tr = rise_t;
    observe(15);
    btn_raw = 1'b0;
    observe(12);
    checks++;
    if (long_n !== 1 || long_t !== tr + 20 || short_n !== 0) begin
      fails++;
      $display("FAIL race_just_long: got long=%0d@%0d short=%0d expected long=1@%0d short=0", long_n, long_t, short_n, tr + 20);
    end
  endtask

  task test_reset_mid_press;
    clear_log();
    btn_raw = 1'b1;
    observe(6);
    observe(5);
    rst_n = 1'b0;
    observe(2);
    checks++;
    if (btn_level !== 1'b0) begin fails++; $display("FAIL midreset_level: got %b expected 0", btn_level); end
    btn_raw = 1'b0;
    observe(2);
    rst_n = 1'b1;
    observe(30);
    checks++;
    if (short_n + long_n + rep_n !== 0) begin
      fails++;
      $display("FAIL midreset_no_pulse: got %0d pulses expected 0", short_n + long_n + rep_n);
    end
    // A clean short press afterwards shows the FSM restarted from IDLE
    clear_log();
    btn_raw = 1'b1;
    observe(10);
    btn_raw = 1'b0;
    observe(10);
    checks++;
    if (short_n !== 1 || long_n !== 0) begin
      fails++;
      $display("FAIL midreset_recover: got short=%0d long=%0d expected short=1 long=0", short_n, long_n);
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_auto_repeat();
    test_threshold_race();
    test_reset_mid_press();
    checks++;
    if (both_n !== 0) begin fails++; $display("FAIL exclusive_pulses: got %0d overlaps expected 0", both_n); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
